// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the colour format exchanged
// between vga_timing and the screen renderer.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int CNT_W = 10;
    localparam int RED_W = 3;
    localparam int GRN_W = 3;
    localparam int BLU_W = 2;

    typedef logic [CNT_W-1:0] coord_t;

    typedef struct packed {
        logic [RED_W-1:0] r;
        logic [GRN_W-1:0] g;
        logic [BLU_W-1:0] b;
    } rgb_t;

    // Half-open window test used for both sync pulses.
    function automatic logic in_span(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_timing_pixel_tick_gen.sv
// Board-clock divider producing a one-clk enable every CLK_DIV clocks.
// Kept standalone so other slow-rate blocks can share the same tick source.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             tick_reg;
    logic             tick_next;

    // The tick is registered from the next count so it is high exactly while
    // div_cnt sits at its last value, yet still resets to 0 when CLK_DIV is 1.
    always_comb begin
        div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
        tick_next    = (div_cnt_next == DIV_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            tick_reg    <= tick_next;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: pixel counters for the renderer plus an output
// register that lines up colour, blanking and sync on the same pixel edge.
module vga_timing #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       de,
    output logic       pix_tick,
    output logic       frame_start,
    input  logic [2:0] pix_r,
    input  logic [2:0] pix_g,
    input  logic [1:0] pix_b,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);

    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST  = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOT - 1);
    localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
    localparam coord_t HS_LO   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_HI   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_LO   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_HI   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    logic   tick;
    coord_t sx_reg, sx_next;
    coord_t sy_reg, sy_next;
    rgb_t   rgb_reg, rgb_next;
    rgb_t   pix_rgb;
    logic   hs_reg, hs_next;
    logic   vs_reg, vs_next;
    logic   line_end, frame_end;
    logic   de_int, hs_zone, vs_zone;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign pix_rgb = '{r: pix_r, g: pix_g, b: pix_b};

    // >= rather than == so a counter can never run past its maximum.
    always_comb begin
        line_end  = (sx_reg >= H_LAST);
        frame_end = (sy_reg >= V_LAST);
        sx_next   = sx_reg;
        sy_next   = sy_reg;
        if (tick) begin
            if (line_end) begin
                sx_next = '0;
                sy_next = frame_end ? '0 : sy_reg + 1'b1;
            end else begin
                sx_next = sx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_reg <= '0;
            sy_reg <= '0;
        end else begin
            sx_reg <= sx_next;
            sy_reg <= sy_next;
        end
    end

    // Output stage samples the pre-increment position, so colour and both
    // syncs describe the same pixel one tick after it was presented.
    always_comb begin
        de_int   = (sx_reg < H_ACT_C) && (sy_reg < V_ACT_C);
        hs_zone  = in_span(sx_reg, HS_LO, HS_HI);
        vs_zone  = in_span(sy_reg, VS_LO, VS_HI);
        rgb_next = rgb_reg;
        hs_next  = hs_reg;
        vs_next  = vs_reg;
        if (tick) begin
            rgb_next = de_int ? pix_rgb : '0;
            hs_next  = hs_zone ? SYNC_ON : SYNC_OFF;
            vs_next  = vs_zone ? SYNC_ON : SYNC_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_reg <= '0;
            hs_reg  <= SYNC_OFF;
            vs_reg  <= SYNC_OFF;
        end else begin
            rgb_reg <= rgb_next;
            hs_reg  <= hs_next;
            vs_reg  <= vs_next;
        end
    end

    assign sx          = sx_reg;
    assign sy          = sy_reg;
    assign de          = de_int;
    assign pix_tick    = tick;
    assign frame_start = tick && (sx_reg == '0) && (sy_reg == '0);
    assign vga_r       = rgb_reg.r;
    assign vga_g       = rgb_reg.g;
    assign vga_b       = rgb_reg.b;
    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size raster plus two shrunken rasters so whole
// frames, mid-frame reset and the CLK_DIV=1 build fit a short run.
module tb_vga_timing;

    typedef struct packed {
        int d;   int ha;  int hfp; int hsy; int hbp;
        int va;  int vfp; int vsy; int vbp; int sa;
    } cfg_t;

    localparam cfg_t CFG_A = '{d:4, ha:640, hfp:16, hsy:96, hbp:48, va:480, vfp:10, vsy:2, vbp:33, sa:0};
    localparam cfg_t CFG_B = '{d:3, ha:16,  hfp:2,  hsy:4,  hbp:3,  va:8,   vfp:2,  vsy:2, vbp:3,  sa:0};
    localparam cfg_t CFG_C = '{d:1, ha:20,  hfp:3,  hsy:5,  hbp:4,  va:10,  vfp:1,  vsy:3, vbp:2,  sa:1};

    typedef struct packed {
        logic [9:0] sx; logic [9:0] sy;
        logic de; logic tick; logic fs; logic hs; logic vs;
        logic [7:0] rgb;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic [7:0] pix = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         e_a = 0, e_b = 0, e_c = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00, last_c = 8'h00;

    always #5 clk = ~clk;

    logic [9:0] sx_a, sy_a, sx_b, sy_b, sx_c, sy_c;
    logic de_a, tick_a, fs_a, hs_a, vs_a, de_b, tick_b, fs_b, hs_b, vs_b, de_c, tick_c, fs_c, hs_c, vs_c;
    logic [2:0] r_a, g_a, r_b, g_b, r_c, g_c;
    logic [1:0] b_a, b_b, b_c;
    obs_t act_a, act_b, act_c;
    assign act_a = {sx_a, sy_a, de_a, tick_a, fs_a, hs_a, vs_a, r_a, g_a, b_a};
    assign act_b = {sx_b, sy_b, de_b, tick_b, fs_b, hs_b, vs_b, r_b, g_b, b_b};
    assign act_c = {sx_c, sy_c, de_c, tick_c, fs_c, hs_c, vs_c, r_c, g_c, b_c};

    vga_timing #(.CLK_DIV(CFG_A.d), .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hfp), .H_SYNC(CFG_A.hsy), .H_BP(CFG_A.hbp),
                 .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vfp), .V_SYNC(CFG_A.vsy), .V_BP(CFG_A.vbp), .SYNC_ACTIVE(CFG_A.sa))
    dut_a (.clk(clk), .rst_n(rst_a), .sx(sx_a), .sy(sy_a), .de(de_a), .pix_tick(tick_a), .frame_start(fs_a),
           .pix_r(pix[7:5]), .pix_g(pix[4:2]), .pix_b(pix[1:0]),
           .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a));

    vga_timing #(.CLK_DIV(CFG_B.d), .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hfp), .H_SYNC(CFG_B.hsy), .H_BP(CFG_B.hbp),
                 .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vfp), .V_SYNC(CFG_B.vsy), .V_BP(CFG_B.vbp), .SYNC_ACTIVE(CFG_B.sa))
    dut_b (.clk(clk), .rst_n(rst_b), .sx(sx_b), .sy(sy_b), .de(de_b), .pix_tick(tick_b), .frame_start(fs_b),
           .pix_r(pix[7:5]), .pix_g(pix[4:2]), .pix_b(pix[1:0]),
           .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b));

    vga_timing #(.CLK_DIV(CFG_C.d), .H_ACTIVE(CFG_C.ha), .H_FP(CFG_C.hfp), .H_SYNC(CFG_C.hsy), .H_BP(CFG_C.hbp),
                 .V_ACTIVE(CFG_C.va), .V_FP(CFG_C.vfp), .V_SYNC(CFG_C.vsy), .V_BP(CFG_C.vbp), .SYNC_ACTIVE(CFG_C.sa))
    dut_c (.clk(clk), .rst_n(rst_c), .sx(sx_c), .sy(sy_c), .de(de_c), .pix_tick(tick_c), .frame_start(fs_c),
           .pix_r(pix[7:5]), .pix_g(pix[4:2]), .pix_b(pix[1:0]),
           .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .vga_hs(hs_c), .vga_vs(vs_c));

    // Edge e (counted from reset release) carries a pixel tick when e is a
    // multiple of the divider, except the very first edge.
    function automatic bit tick_edge(input cfg_t c, input int e);
        return (e >= 2) && (e % c.d == 0);
    endfunction

    function automatic int ticks_upto(input cfg_t c, input int e);
        if (e <= 0) return 0;
        return (c.d == 1) ? e - 1 : e / c.d;
    endfunction

    function automatic int frame_px(input cfg_t c);
        return (c.ha + c.hfp + c.hsy + c.hbp) * (c.va + c.vfp + c.vsy + c.vbp);
    endfunction

    // Expected visible state after e edges: raster position is just the tick
    // count modulo the frame size; the pins show the previously ticked pixel.
    function automatic obs_t model(input cfg_t c, input int e, input logic [7:0] last);
        int ht, n, t, p, q;
        obs_t o;
        ht = c.ha + c.hfp + c.hsy + c.hbp;
        n  = frame_px(c);
        t  = ticks_upto(c, e);
        p  = t % n;
        o.sx   = 10'(p % ht);
        o.sy   = 10'(p / ht);
        o.de   = ((p % ht) < c.ha) && ((p / ht) < c.va);
        o.tick = tick_edge(c, e + 1);
        o.fs   = o.tick && (p == 0);
        o.hs   = (c.sa == 0);
        o.vs   = (c.sa == 0);
        o.rgb  = 8'h00;
        if (t > 0) begin
            q = (t - 1) % n;
            if ((q % ht) >= c.ha + c.hfp && (q % ht) < c.ha + c.hfp + c.hsy) o.hs = (c.sa != 0);
            if ((q / ht) >= c.va + c.vfp && (q / ht) < c.va + c.vfp + c.vsy) o.vs = (c.sa != 0);
            if ((q % ht) < c.ha && (q / ht) < c.va) o.rgb = last;
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("sx=%0d sy=%0d de=%0b tick=%0b fs=%0b hs=%0b vs=%0b rgb=%02h",
                         o.sx, o.sy, o.de, o.tick, o.fs, o.hs, o.vs, o.rgb);
    endfunction

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) e_a <= 0;
        else begin
            if (tick_edge(CFG_A, e_a + 1)) last_a <= pix;
            e_a <= e_a + 1;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) e_b <= 0;
        else begin
            if (tick_edge(CFG_B, e_b + 1)) last_b <= pix;
            e_b <= e_b + 1;
        end
    end

    always @(posedge clk or negedge rst_c) begin
        if (!rst_c) e_c <= 0;
        else begin
            if (tick_edge(CFG_C, e_c + 1)) last_c <= pix;
            e_c <= e_c + 1;
        end
    end

    task automatic test_reset();
        obs_t exp;
        pix = 8'($urandom);
        repeat (3) @(negedge clk);
        exp = model(CFG_A, e_a, last_a);
        checks++; if (act_a !== exp) begin errors++; $display("FAIL reset_a: got %s, expected %s", fmt(act_a), fmt(exp)); end
        exp = model(CFG_B, e_b, last_b);
        checks++; if (act_b !== exp) begin errors++; $display("FAIL reset_b: got %s, expected %s", fmt(act_b), fmt(exp)); end
        exp = model(CFG_C, e_c, last_c);
        checks++; if (act_c !== exp) begin errors++; $display("FAIL reset_c: got %s, expected %s", fmt(act_c), fmt(exp)); end
        $display("reset: all three rasters checked while held in reset");
    endtask

    task automatic test_first_tick();
        obs_t exp;
        rst_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            pix = 8'($urandom);
            @(negedge clk);
            exp = model(CFG_A, e_a, last_a);
            checks++; if (act_a !== exp) begin errors++; $display("FAIL first_tick edge %0d: got %s, expected %s", i, fmt(act_a), fmt(exp)); end
            if (i == 3) begin
                checks++; if (tick_a !== 1'b1) begin errors++; $display("FAIL first_tick_high: tick=%b, expected 1", tick_a); end
            end
            if (i == 4) begin
                checks++; if (sx_a !== 10'd1) begin errors++; $display("FAIL first_tick_sx: sx=%0d, expected 1", sx_a); end
            end
        end
        $display("first_tick: divider start-up after release checked");
    endtask

    task automatic test_line_a();
        int r_hi = 0, hs_lo = 0, first_hs = -1, q;
        obs_t exp;
        pix = 8'hFF;
        for (int k = 0; k < 6600 && ticks_upto(CFG_A, e_a) < 1600; k++) begin
            @(negedge clk);
            exp = model(CFG_A, e_a, last_a);
            checks++; if (act_a !== exp) begin errors++; $display("FAIL line_a e=%0d: got %s, expected %s", e_a, fmt(act_a), fmt(exp)); end
            if (tick_edge(CFG_A, e_a)) begin
                q = ticks_upto(CFG_A, e_a) - 1;
                if (q >= 800 && q < 1600) begin
                    if (r_a == 3'd7) r_hi++;
                    if (hs_a == 1'b0) begin
                        hs_lo++;
                        if (first_hs < 0) first_hs = q - 800;
                    end
                end
            end
        end
        checks++; if (r_hi !== 640) begin errors++; $display("FAIL line_red_ticks: %0d, expected 640", r_hi); end
        checks++; if (hs_lo !== 96) begin errors++; $display("FAIL line_hs_width: %0d, expected 96", hs_lo); end
        checks++; if (first_hs !== 656) begin errors++; $display("FAIL line_hs_start: sx=%0d, expected 656", first_hs); end
        $display("line_a: red ticks=%0d hs low ticks=%0d hs from sx=%0d", r_hi, hs_lo, first_hs);
    endtask

    task automatic test_blanking_a();
        int seen_639 = 0, seen_640 = 0;
        obs_t exp;
        for (int k = 0; k < 3300 && ticks_upto(CFG_A, e_a) < 2400; k++) begin
            pix = 8'($urandom_range(1, 255));
            @(negedge clk);
            exp = model(CFG_A, e_a, last_a);
            checks++; if (act_a !== exp) begin errors++; $display("FAIL blank_a e=%0d: got %s, expected %s", e_a, fmt(act_a), fmt(exp)); end
            if (sx_a == 10'd639) begin
                seen_639++;
                checks++; if (de_a !== 1'b1) begin errors++; $display("FAIL de_639: de=%b, expected 1", de_a); end
            end
            if (sx_a == 10'd640) begin
                seen_640++;
                checks++; if (de_a !== 1'b0) begin errors++; $display("FAIL de_640: de=%b, expected 0", de_a); end
            end
            if (tick_edge(CFG_A, e_a) && ((ticks_upto(CFG_A, e_a) - 1) % 800) >= 640) begin
                checks++; if ({r_a, g_a, b_a} !== 8'h00) begin errors++; $display("FAIL blank_rgb: rgb=%02h, expected 00", {r_a, g_a, b_a}); end
            end
        end
        checks++; if (seen_639 == 0 || seen_640 == 0) begin errors++; $display("FAIL de_edges_reached: 639 seen %0d, 640 seen %0d, expected both >0", seen_639, seen_640); end
        $display("blanking_a: de edge and blank-rgb checks done");
    endtask

    task automatic test_frame_b();
        int fs_seen = 0, last_fs = -1, vs_lo = 0, q, span, n_clk, exp_fs, ht;
        obs_t exp;
        span  = frame_px(CFG_B);
        ht    = CFG_B.ha + CFG_B.hfp + CFG_B.hsy + CFG_B.hbp;
        n_clk = 4 * span * CFG_B.d;
        exp_fs = (n_clk - (CFG_B.d - 1)) / (span * CFG_B.d) + 1;
        rst_b = 1'b1;
        for (int k = 0; k < n_clk; k++) begin
            pix = 8'($urandom);
            @(negedge clk);
            exp = model(CFG_B, e_b, last_b);
            checks++; if (act_b !== exp) begin errors++; $display("FAIL frame_b e=%0d: got %s, expected %s", e_b, fmt(act_b), fmt(exp)); end
            if (fs_b) begin
                if (last_fs >= 0) begin
                    checks++; if (e_b - last_fs !== span * CFG_B.d) begin errors++; $display("FAIL fs_period_b: %0d clks, expected %0d", e_b - last_fs, span * CFG_B.d); end
                end
                last_fs = e_b;
                fs_seen++;
            end
            if (tick_edge(CFG_B, e_b)) begin
                q = ticks_upto(CFG_B, e_b) - 1;
                if (q >= span && q < 2 * span && vs_b == (CFG_B.sa != 0)) vs_lo++;
            end
        end
        checks++; if (fs_seen !== exp_fs) begin errors++; $display("FAIL fs_count_b: %0d, expected %0d", fs_seen, exp_fs); end
        checks++; if (vs_lo !== CFG_B.vsy * ht) begin errors++; $display("FAIL vs_width_b: %0d ticks, expected %0d", vs_lo, CFG_B.vsy * ht); end
        $display("frame_b: frame_start pulses=%0d vs active ticks=%0d", fs_seen, vs_lo);
    endtask

    task automatic test_mid_reset_b();
        int k = 0;
        obs_t exp;
        while (!(sx_b == 10'd10 && sy_b == 10'd5) && k < 2000) begin
            pix = 8'($urandom);
            @(negedge clk);
            k++;
        end
        checks++; if (k >= 2000) begin errors++; $display("FAIL mid_reset_reach: waited %0d clks, limit 2000", k); end
        #2 rst_b = 1'b0;
        #1 exp = model(CFG_B, 0, 8'h00);
        checks++; if (act_b !== exp) begin errors++; $display("FAIL mid_reset_async: got %s, expected %s", fmt(act_b), fmt(exp)); end
        repeat (3) begin
            @(negedge clk);
            exp = model(CFG_B, e_b, last_b);
            checks++; if (act_b !== exp) begin errors++; $display("FAIL mid_reset_hold: got %s, expected %s", fmt(act_b), fmt(exp)); end
        end
        rst_b = 1'b1;
        for (int i = 0; i < 600; i++) begin
            pix = 8'($urandom);
            @(negedge clk);
            exp = model(CFG_B, e_b, last_b);
            checks++; if (act_b !== exp) begin errors++; $display("FAIL mid_reset_resume e=%0d: got %s, expected %s", e_b, fmt(act_b), fmt(exp)); end
        end
        $display("mid_reset_b: reset at (10,5) and resume from (0,0) checked");
    endtask

    task automatic test_div1_c();
        int fs_seen = 0, last_fs = -1, span, n_clk, exp_fs;
        obs_t exp;
        span   = frame_px(CFG_C);
        n_clk  = 2 * span + 20;
        exp_fs = (n_clk - 1) / span + 1;
        rst_c = 1'b1;
        for (int k = 0; k < n_clk; k++) begin
            pix = 8'($urandom);
            @(negedge clk);
            exp = model(CFG_C, e_c, last_c);
            checks++; if (act_c !== exp) begin errors++; $display("FAIL div1_c e=%0d: got %s, expected %s", e_c, fmt(act_c), fmt(exp)); end
            checks++; if (tick_c !== 1'b1) begin errors++; $display("FAIL div1_tick e=%0d: tick=%b, expected 1", e_c, tick_c); end
            if (fs_c) begin
                if (last_fs >= 0) begin
                    checks++; if (e_c - last_fs !== span) begin errors++; $display("FAIL fs_period_c: %0d clks, expected %0d", e_c - last_fs, span); end
                end
                last_fs = e_c;
                fs_seen++;
            end
        end
        checks++; if (fs_seen !== exp_fs) begin errors++; $display("FAIL fs_count_c: %0d, expected %0d", fs_seen, exp_fs); end
        $display("div1_c: frame_start pulses=%0d over %0d clks", fs_seen, n_clk);
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line_a();
        test_blanking_a();
        test_frame_b();
        test_mid_reset_b();
        test_div1_c();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
